// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle core for the 9-bit ISA.
// Fetch happens through a synchronous instruction memory. Data memory uses a
// req/ack handshake, so data memories with variable latency are supported.
// Define MC_CPU_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
// The default build leaves the counters out.
module mc_cpu_core #(
  parameter int          DW     = 8,
  parameter int          PW     = 9,
  parameter int unsigned RST_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          imem_rd,
  output logic [PW-1:0] imem_addr,
  input  logic [8:0]    imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
`ifdef MC_CPU_PERF_CNT_EN
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   ret_cnt,
`endif
  output logic          zero
);

  localparam logic [2:0]    OP_ADD     = 3'd0;
  localparam logic [2:0]    OP_SUB     = 3'd1;
  localparam logic [2:0]    OP_AND     = 3'd2;
  localparam logic [2:0]    OP_SHF     = 3'd3;
  localparam logic [2:0]    OP_LDI     = 3'd4;
  localparam logic [2:0]    OP_LDR     = 3'd5;
  localparam logic [2:0]    OP_STR     = 3'd6;
  localparam logic [2:0]    OP_BZ      = 3'd7;
  localparam logic [8:0]    HALT_INSTR = 9'h1FF;
  localparam logic [PW-1:0] START_PC   = PW'(RST_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pc_reg, pc_next;
  logic [8:0]    ir_reg;
  logic          zero_reg;
  logic [DW-1:0] rf_reg [8];

  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  // Decode fields. EXEC works straight from the memory output word.
  // MEM works from the latched IR.
  logic [2:0]    op, ra_idx, rb_idx, shf_idx, shamt;
  logic [DW-1:0] ra_val, rb_val, shf_val, shf_res;
  logic [PW-1:0] br_off, pc_inc;
  logic [2:0]    mem_op;
  logic [DW-1:0] mem_ra_val, mem_rb_val;

  assign op      = imem_data[8:6];
  assign ra_idx  = imem_data[5:3];
  assign rb_idx  = imem_data[2:0];
  assign shf_idx = imem_data[4:2];
  assign shamt   = {1'b0, imem_data[1:0]} + 3'd1;
  assign ra_val  = rf_reg[ra_idx];
  assign rb_val  = rf_reg[rb_idx];
  assign shf_val = rf_reg[shf_idx];
  assign shf_res = imem_data[5] ? (shf_val >> shamt) : (shf_val << shamt);
  assign br_off  = {{(PW-3){rb_idx[2]}}, rb_idx};
  assign pc_inc  = pc_reg + PW'(1);

  assign mem_op     = ir_reg[8:6];
  assign mem_ra_val = rf_reg[ir_reg[5:3]];
  assign mem_rb_val = rf_reg[ir_reg[2:0]];

  // The data address and store data come from the latched IR and registers.
  // Registers are not written while in MEM, so both stay stable until ack.
  assign dmem_addr  = mem_rb_val;
  assign dmem_wdata = mem_ra_val;
  assign imem_addr  = pc_reg;
  assign zero       = zero_reg;

  // Next-state, datapath control and strobes, all decoded from the current state.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    rf_we      = 1'b0;
    rf_waddr   = ra_idx;
    rf_wdata   = '0;
    done       = 1'b0;
    imem_rd    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = START_PC;
        end
      end
      S_FETCH: begin
        imem_rd    = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (imem_data == HALT_INSTR) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
          pc_next    = pc_inc;
          case (op)
            OP_ADD: begin
              rf_we    = 1'b1;
              rf_wdata = ra_val + rb_val;
            end
            OP_SUB: begin
              rf_we    = 1'b1;
              rf_wdata = ra_val - rb_val;
            end
            OP_AND: begin
              rf_we    = 1'b1;
              rf_wdata = ra_val & rb_val;
            end
            OP_SHF: begin
              rf_we    = 1'b1;
              rf_waddr = shf_idx;
              rf_wdata = shf_res;
            end
            OP_LDI: begin
              rf_we    = 1'b1;
              rf_waddr = 3'd1;
              rf_wdata = DW'(imem_data[5:0]);
            end
            OP_BZ: begin
              if (ra_val == '0) pc_next = pc_reg + br_off;
            end
            default: begin
              // LDR and STR keep the PC until the handshake completes.
              state_next = S_MEM;
              pc_next    = pc_reg;
            end
          endcase
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (mem_op == OP_STR);
        if (dmem_ack) begin
          state_next = S_FETCH;
          pc_next    = pc_inc;
          if (mem_op == OP_LDR) begin
            rf_we    = 1'b1;
            rf_waddr = ir_reg[5:3];
            rf_wdata = dmem_rdata;
          end
        end
      end
      S_HALT: begin
        done = 1'b1;
        if (start) begin
          state_next = S_FETCH;
          pc_next    = START_PC;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset drops the MEM strobes at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // PC, IR and zero flag. The zero flag tracks every register write result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg   <= START_PC;
      ir_reg   <= '0;
      zero_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (state_reg == S_EXEC) ir_reg <= imem_data;
      if (rf_we) zero_reg <= (rf_wdata == '0);
    end
  end

  // Register file r0..r7. The write lands at the end of EXEC/MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
    end else if (rf_we) begin
      rf_reg[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MC_CPU_PERF_CNT_EN
  logic accept, retire, busy;

  assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_HALT));
  assign busy   = (state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_MEM);
  assign retire = ((state_reg == S_EXEC) && (imem_data != HALT_INSTR) &&
                   (op != OP_LDR) && (op != OP_STR)) ||
                  ((state_reg == S_MEM) && dmem_ack);

  // Saturating cycle and retire counters. Both clear on every accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (accept) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (busy && (cyc_cnt != 32'hFFFF_FFFF))   cyc_cnt <= cyc_cnt + 32'd1;
      if (retire && (ret_cnt != 32'hFFFF_FFFF)) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// Scoreboard bench for mc_cpu_core.
// The stimulus pushes expected fetches, memory transactions and done events
// into queues. A monitor pops an entry and compares it whenever the DUT
// presents the corresponding output.
module tb_mc_cpu_core;
  localparam int DW = 8;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          done, imem_rd, dmem_req, dmem_we, dmem_ack, zero;
  logic [PW-1:0] imem_addr;
  logic [8:0]    imem_data = '0;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          ack_model = 1'b0;
  logic          ack_force = 1'b0;
`ifdef MC_CPU_PERF_CNT_EN
  logic [31:0]   cyc_cnt, ret_cnt;
`endif

  assign dmem_ack = ack_model | ack_force;

  always #5 clk = ~clk;

  mc_cpu_core #(.DW(DW), .PW(PW), .RST_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
`ifdef MC_CPU_PERF_CNT_EN
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt),
`endif
    .zero       (zero)
  );

  typedef struct {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    int            len;
  } mexp_t;

  typedef struct {
    int   cycles;
    logic z;
  } dexp_t;

  int            checks = 0;
  int            failures = 0;
  mexp_t         mem_q[$];
  dexp_t         done_q[$];
  logic [PW-1:0] fetch_q[$];
  int            cyc_now = 0;
  int            t_start = 0;
  int            mem_wait = 0;
  int            wait_cnt = 0;
  logic [8:0]    imem [512];
  logic [DW-1:0] dmem [256];

  // Monitor state.
  logic          mon_done_prev = 1'b0;
  int            mon_req_len = 0;
  logic [DW-1:0] mon_a0, mon_d0;
  logic          mon_w0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_now++;

  // Synchronous instruction memory: the data is valid the cycle after imem_rd.
  always @(posedge clk) if (imem_rd) imem_data <= imem[imem_addr];

  // Data memory: acks after mem_wait idle request cycles and holds ack for one cycle.
  always @(negedge clk) begin
    if (ack_model) begin
      ack_model = 1'b0;
      wait_cnt  = 0;
    end else if (dmem_req) begin
      if (wait_cnt == mem_wait) begin
        dmem_rdata = dmem[dmem_addr];
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        ack_model = 1'b1;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: compares fetches, memory handshakes and done events against the queues.
  initial begin
    mexp_t m;
    dexp_t d;
    logic [PW-1:0] f;
    forever begin
      @(negedge clk);
      #1;
      if (imem_rd) begin
        if (fetch_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL fetch_unexpected: got addr 0x%0h, no fetch expected", imem_addr);
        end else begin
          f = fetch_q.pop_front();
          chk("fetch_pc", imem_addr, f);
        end
      end
      if (dmem_req) begin
        if (mon_req_len == 0) begin
          mon_a0 = dmem_addr; mon_d0 = dmem_wdata; mon_w0 = dmem_we;
        end
        mon_req_len++;
        if (dmem_ack) begin
          if (mem_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_unexpected: got addr 0x%0h we %0b, no transaction expected", dmem_addr, dmem_we);
          end else begin
            m = mem_q.pop_front();
            chk("mem_we", dmem_we, m.we);
            chk("mem_addr", dmem_addr, m.addr);
            if (m.we) chk("mem_wdata", dmem_wdata, m.data);
            chk("mem_req_len", mon_req_len, m.len);
            chk("mem_addr_stable", dmem_addr, mon_a0);
            chk("mem_wdata_stable", dmem_wdata, mon_d0);
            chk("mem_we_stable", dmem_we, mon_w0);
          end
          mon_req_len = 0;
        end
      end else begin
        mon_req_len = 0;
      end
      if (done && !mon_done_prev) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got done=1, no done expected");
        end else begin
          d = done_q.pop_front();
          chk("done_latency", cyc_now - t_start, d.cycles);
          chk("zero_at_done", zero, d.z);
        end
      end
      mon_done_prev = done;
    end
  end

  task automatic exp_fetch_range(input int n);
    for (int i = 0; i < n; i++) fetch_q.push_back(PW'(i));
  endtask

  task automatic exp_mem(input logic we, input int addr, input int data, input int len);
    mexp_t m;
    m.we = we; m.addr = DW'(addr); m.data = DW'(data); m.len = len;
    mem_q.push_back(m);
  endtask

  // Pulse start, then wait for done with a bounded cycle budget.
  task automatic run(input int exp_cyc, input logic exp_z, input int exp_ret);
    dexp_t d;
    d.cycles = exp_cyc; d.z = exp_z;
    done_q.push_back(d);
    @(negedge clk);
    start = 1'b1;
    t_start = cyc_now + 1;
    @(negedge clk);
    start = 1'b0;
`ifdef MC_CPU_PERF_CNT_EN
    chk("cyc_cnt_cleared", cyc_cnt, 0);
    chk("ret_cnt_cleared", ret_cnt, 0);
`endif
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("done_reached", done, 1);
`ifdef MC_CPU_PERF_CNT_EN
    chk("cyc_cnt_at_done", cyc_cnt, exp_cyc);
    chk("ret_cnt_at_done", ret_cnt, exp_ret);
`endif
  endtask

  // Store register idx to mem[r0] (r0 is never written, so the address is 0), then halt.
  task automatic dump(input logic [2:0] idx, input int exp_val, input logic exp_z);
    imem[0] = {3'd6, idx, 3'd0};
    imem[1] = 9'h1FF;
    exp_fetch_range(2);
    exp_mem(1'b1, 0, exp_val, mem_wait + 1);
    run(5 + mem_wait, exp_z, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem[i] = 9'h1FF;
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_zero", zero, 0);
    chk("rst_imem_addr", imem_addr, 0);
    reset = 1'b1;

    // Program 1: LDI 5; ADD r1,r1; HALT -> r1=10, zero=0.
    mem_wait = 0;
    imem[0] = 9'h105; imem[1] = 9'h009; imem[2] = 9'h1FF;
    exp_fetch_range(3);
    run(6, 1'b0, 2);
    $display("TXN prog1 done: r1 expected 0x0a");
    dump(3'd1, 8'h0A, 1'b0);

    // Program 2: LDI 0; BZ r1,+2; LDI 7 (skipped); HALT.
    imem[0] = 9'h100; imem[1] = 9'h1CA; imem[2] = 9'h107; imem[3] = 9'h1FF;
    fetch_q.push_back(9'd0); fetch_q.push_back(9'd1); fetch_q.push_back(9'd3);
    run(6, 1'b1, 2);
    $display("TXN prog2 done: r1 expected 0x00");
    dump(3'd1, 0, 1'b1);

    // Program 3: r2=20, r3=33; STR r2->[r3]; LDR r4<-[r3]; three-cycle memory wait.
    mem_wait = 3;
    imem[0] = 9'h114; imem[1] = 9'h011; imem[2] = 9'h121; imem[3] = 9'h019;
    imem[4] = 9'h193; imem[5] = 9'h163; imem[6] = 9'h1FF;
    exp_fetch_range(7);
    exp_mem(1'b1, 33, 20, 4);
    exp_mem(1'b0, 33, 0, 4);
    run(22, 1'b0, 6);
    $display("TXN prog3 done: r4 expected 0x14");
    dump(3'd4, 20, 1'b0);

    // Program 4: LDI 0x3F; SHL 4 -> 0xF0; STR; SHR 2 -> 0x3C; STR; SUB r1,r1 -> 0.
    mem_wait = 0;
    imem[0] = 9'h13F; imem[1] = 9'h0C7; imem[2] = 9'h188; imem[3] = 9'h0E5;
    imem[4] = 9'h188; imem[5] = 9'h049; imem[6] = 9'h1FF;
    exp_fetch_range(7);
    exp_mem(1'b1, 0, 8'hF0, 1);
    exp_mem(1'b1, 0, 8'h3C, 1);
    run(16, 1'b1, 6);
    $display("TXN prog4 done: zero expected 1");

    // Reset during MEM with an ack still pending. A late ack must not write r5.
    dmem[0] = 8'h55;
    mem_wait = 10;
    imem[0] = 9'h168; imem[1] = 9'h1FF;
    fetch_q.push_back(9'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !dmem_req; i++) @(negedge clk);
    chk("req_before_reset", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_dmem_req", dmem_req, 0);
    chk("rst_mid_dmem_we", dmem_we, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_imem_rd", imem_rd, 0);
    chk("rst_mid_zero", zero, 0);
    chk("rst_mid_imem_addr", imem_addr, 0);
`ifdef MC_CPU_PERF_CNT_EN
    chk("rst_mid_cyc_cnt", cyc_cnt, 0);
    chk("rst_mid_ret_cnt", ret_cnt, 0);
`endif
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    mem_wait = 0;
    $display("TXN reset-in-MEM done: r5 and r2 expected 0x00");
    dump(3'd5, 0, 1'b0);
    dump(3'd2, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("fetch_q_drained", fetch_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
